// File: rtl/llpm_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : llpm_mem_pkg
// Description : Shared constants and helpers for the packed block-RAM request
//               format {addr, data, wr}, with wr at bit 0.
// Revision    : 1.0 - initial release
// ============================================================================
package llpm_mem_pkg;

    // Width of every statistics counter
    localparam int unsigned StatWidth = 32;

    // Fixed field offsets of the packed request
    localparam int unsigned ReqWrBit   = 0;
    localparam int unsigned ReqDataLsb = 1;

    // Data field occupies [Width:1]
    function automatic int unsigned req_data_msb(input int unsigned width);
        return width;
    endfunction

    // Address field occupies [Width+AddrWidth:Width+1]
    function automatic int unsigned req_addr_lsb(input int unsigned width);
        return width + 1;
    endfunction

    function automatic int unsigned req_addr_msb(input int unsigned width,
                                                 input int unsigned addr_width);
        return width + addr_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/llpm_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : llpm_tag_fifo
// Description : Small synchronous FIFO holding requester tags in issue order.
//               Head is read combinationally; occupancy is exposed as count.
// Revision    : 1.0 - initial release
// ============================================================================
module llpm_tag_fifo #(
    parameter int WIDTH       = 2,
    parameter int DEPTH       = 4,
    parameter int CLOG2_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [CLOG2_DEPTH:0]   count,
    output logic                   empty,
    output logic                   full
);

    localparam logic [CLOG2_DEPTH-1:0] c_last_ptr = CLOG2_DEPTH'(DEPTH - 1);
    localparam logic [CLOG2_DEPTH:0]   c_depth    = (CLOG2_DEPTH + 1)'(DEPTH);

    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic [CLOG2_DEPTH-1:0] r_wr_ptr;
    logic [CLOG2_DEPTH-1:0] r_rd_ptr;
    logic [CLOG2_DEPTH:0]   r_count;
    logic                   w_do_push;
    logic                   w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_depth);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Tag storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count alone
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arbiter
// Description : Round-robin arbiter sharing one block-RAM port among NumReqs
//               requesters. A registered issue stage drives the RAM port and
//               an in-order tag FIFO routes each response to its requester.
//               Optional statistics counters are enabled by defining
//               BRAM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arbiter
    import llpm_mem_pkg::*;
#(
    parameter int NumReqs          = 4,
    parameter int CLog2NumReqs     = 2,
    parameter int Width            = 8,
    parameter int AddrWidth        = 8,
    parameter int MaxInFlight      = 4,
    parameter int CLog2MaxInFlight = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NumReqs-1:0][Width+AddrWidth:0]     reqs,
    input  logic [NumReqs-1:0]                        req_valids,
    output logic [NumReqs-1:0]                        req_bps,
    output logic [NumReqs-1:0][Width-1:0]             resps,
    output logic [NumReqs-1:0]                        resp_valids,
    input  logic [NumReqs-1:0]                        resp_bps,
    output logic [Width+AddrWidth:0]                  mem_req,
    output logic                                      mem_req_valid,
    input  logic                                      mem_req_bp,
    input  logic [Width-1:0]                          mem_resp,
    input  logic                                      mem_resp_valid,
    output logic                                      mem_resp_bp
`ifdef BRAM_ARB_STATS_EN
    ,
    output logic [NumReqs-1:0][StatWidth-1:0]         stat_grants,
    output logic [StatWidth-1:0]                      stat_orphans
`endif
);

    localparam logic [CLog2NumReqs-1:0]   c_last_req = CLog2NumReqs'(NumReqs - 1);
    localparam logic [CLog2NumReqs:0]     c_num_reqs = (CLog2NumReqs + 1)'(NumReqs);
    localparam logic [CLog2MaxInFlight:0] c_max_in_flight = (CLog2MaxInFlight + 1)'(MaxInFlight);

    logic [CLog2NumReqs-1:0]   r_rr_ptr;
    logic [Width+AddrWidth:0]  r_mem_req;
    logic                      r_mem_req_valid;

    logic [CLog2NumReqs-1:0]   w_grant;
    logic                      w_any_valid;
    logic                      w_load;
    logic                      w_push;
    logic                      w_pop;
    logic [CLog2NumReqs-1:0]   w_tag;
    logic [CLog2MaxInFlight:0] w_count;
    logic                      w_empty;
    logic                      w_full;

    // Pick the first valid requester at or after rr_ptr, wrapping around
    always_comb begin
        logic [CLog2NumReqs:0] v_sum;
        w_grant     = '0;
        w_any_valid = 1'b0;
        v_sum       = '0;
        for (int k = 0; k < NumReqs; k++) begin
            v_sum = {1'b0, r_rr_ptr} + (CLog2NumReqs + 1)'(k);
            if (v_sum >= c_num_reqs) begin
                v_sum = v_sum - c_num_reqs;
            end
            if (!w_any_valid && req_valids[v_sum[CLog2NumReqs-1:0]]) begin
                w_any_valid = 1'b1;
                w_grant     = v_sum[CLog2NumReqs-1:0];
            end
        end
    end

    // Full is judged on the registered count: a same-cycle pop frees no slot
    assign w_load = !reset && (!r_mem_req_valid || !mem_req_bp) && w_any_valid
                    && (w_count < c_max_in_flight);
    assign w_push = w_load && !w_full;

    generate
        for (genvar i = 0; i < NumReqs; i++) begin : g_req_bp
            assign req_bps[i] = !(w_load && (w_grant == CLog2NumReqs'(i)));
            assign resps[i]   = mem_resp;
        end
    endgenerate

    // Issue register and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_req       <= '0;
            r_mem_req_valid <= 1'b0;
            r_rr_ptr        <= '0;
        end else if (w_load) begin
            r_mem_req       <= reqs[w_grant];
            r_mem_req_valid <= 1'b1;
            r_rr_ptr        <= (w_grant == c_last_req) ? '0 : w_grant + 1'b1;
        end else if (r_mem_req_valid && !mem_req_bp) begin
            r_mem_req_valid <= 1'b0;
        end
    end

    assign mem_req       = r_mem_req;
    assign mem_req_valid = r_mem_req_valid;

    llpm_tag_fifo #(
        .WIDTH       (CLog2NumReqs),
        .DEPTH       (MaxInFlight),
        .CLOG2_DEPTH (CLog2MaxInFlight)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_grant),
        .pop       (w_pop),
        .head      (w_tag),
        .count     (w_count),
        .empty     (w_empty),
        .full      (w_full)
    );

    // Responses with no outstanding tag are orphans: accepted and dropped
    assign mem_resp_bp = w_empty ? 1'b0 : resp_bps[w_tag];
    assign w_pop       = mem_resp_valid && !mem_resp_bp && !w_empty;

    // Steer the response valid to the requester at the head of the tag FIFO
    always_comb begin
        resp_valids = '0;
        if (mem_resp_valid && !w_empty) begin
            resp_valids[w_tag] = 1'b1;
        end
    end

`ifdef BRAM_ARB_STATS_EN
    logic [NumReqs-1:0][StatWidth-1:0] r_stat_grants;
    logic [StatWidth-1:0]              r_stat_orphans;

    // Saturating per-requester grant and orphan-response counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_grants  <= '0;
            r_stat_orphans <= '0;
        end else begin
            if (w_load && (r_stat_grants[w_grant] != '1)) begin
                r_stat_grants[w_grant] <= r_stat_grants[w_grant] + 1'b1;
            end
            if (mem_resp_valid && w_empty && (r_stat_orphans != '1)) begin
                r_stat_orphans <= r_stat_orphans + 1'b1;
            end
        end
    end

    assign stat_grants  = r_stat_grants;
    assign stat_orphans = r_stat_orphans;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_port_arbiter
// Description : Self-checking bench for bram_port_arbiter. A behavioural RAM
//               with configurable in-order latency sits on the memory port;
//               a queue-based reference model predicts grants, the issue
//               register, response routing and back-pressure every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int AW   = 8;
    localparam int RW   = W + AW + 1;
    localparam int MAXF = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0][RW-1:0] reqs;
    logic [N-1:0]         req_valids;
    logic [N-1:0]         req_bps;
    logic [N-1:0][W-1:0]  resps;
    logic [N-1:0]         resp_valids;
    logic [N-1:0]         resp_bps;
    logic [RW-1:0]        mem_req;
    logic                 mem_req_valid;
    logic                 mem_req_bp;
    logic [W-1:0]         mem_resp;
    logic                 mem_resp_valid;
    logic                 mem_resp_bp;
`ifdef BRAM_ARB_STATS_EN
    logic [N-1:0][31:0]   stat_grants;
    logic [31:0]          stat_orphans;
`endif

    bram_port_arbiter #(
        .NumReqs          (N),
        .CLog2NumReqs     (2),
        .Width            (W),
        .AddrWidth        (AW),
        .MaxInFlight      (MAXF),
        .CLog2MaxInFlight (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .reqs           (reqs),
        .req_valids     (req_valids),
        .req_bps        (req_bps),
        .resps          (resps),
        .resp_valids    (resp_valids),
        .resp_bps       (resp_bps),
        .mem_req        (mem_req),
        .mem_req_valid  (mem_req_valid),
        .mem_req_bp     (mem_req_bp),
        .mem_resp       (mem_resp),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_bp    (mem_resp_bp)
`ifdef BRAM_ARB_STATS_EN
        ,
        .stat_grants    (stat_grants),
        .stat_orphans   (stat_orphans)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Stimulus knobs set by the directed sequence
    bit                   rst_now;
    logic [N-1:0]         rv;
    logic [N-1:0][RW-1:0] rq;
    logic [N-1:0]         rbp;
    logic                 mbp;
    int                   lat;
    int                   cyc;
    logic [N-1:0]         acc;
    logic [W-1:0]         last_resp [N];
    bit                   saw_full;

    // Behavioural RAM: in-order responses after lat cycles, writes answer 0
    typedef struct {
        int          ready;
        logic [W-1:0] data;
    } ram_e;
    ram_e        ramq [$];
    logic [W-1:0] ram [256];

    // Reference model state
    int           outq [$];
    bit           em_v;
    logic [RW-1:0] em_req;
    int           last_g;
    int           orphans;
    int           grants [N];

    function automatic logic [RW-1:0] rand_req();
        return {AW'($urandom_range(15)), W'($urandom), 1'($urandom)};
    endfunction

    task automatic step();
        int   g;
        bit   found;
        bit   load;
        int   idx;
        logic [N-1:0] exp_bps;
        logic [N-1:0] exp_rv;
        logic exp_mbp;
        logic [AW-1:0] a;
        ram_e e;
        @(negedge clk);
        reset      = rst_now;
        req_valids = rv;
        reqs       = rq;
        resp_bps   = rbp;
        mem_req_bp = mbp;
        if (mem_req_valid === 1'b1 && !mbp) begin
            a = mem_req[RW-1:W+1];
            if (mem_req[0]) begin
                ram[a] = mem_req[W:1];
                e.data = '0;
            end else begin
                e.data = ram[a];
            end
            e.ready = cyc + lat;
            ramq.push_back(e);
        end
        mem_resp_valid = (ramq.size() > 0) && (ramq[0].ready <= cyc);
        mem_resp       = mem_resp_valid ? ramq[0].data : W'($urandom);
        #1;
        acc = '0;
        if (rst_now) begin
            check("req_bps_in_reset", req_bps, {N{1'b1}});
        end else begin
            g = 0;
            found = 0;
            for (int k = 0; k < N; k++) begin
                idx = (last_g + 1 + k) % N;
                if (!found && rv[idx]) begin
                    g = idx;
                    found = 1;
                end
            end
            load = (!em_v || !mbp) && found && (outq.size() < MAXF);
            exp_bps = {N{1'b1}};
            if (load) exp_bps[g] = 1'b0;
            check("req_bps", req_bps, exp_bps);
            check("mem_req_valid", mem_req_valid, em_v);
            check("mem_req", mem_req, em_req);
            exp_rv  = '0;
            exp_mbp = 1'b0;
            if (outq.size() > 0) begin
                exp_mbp = rbp[outq[0]];
                if (mem_resp_valid) exp_rv[outq[0]] = 1'b1;
            end
            check("resp_valids", resp_valids, exp_rv);
            check("mem_resp_bp", mem_resp_bp, exp_mbp);
            if (exp_rv != '0) begin
                check("resps", resps[outq[0]], mem_resp);
                last_resp[outq[0]] = resps[outq[0]];
            end
            if (outq.size() == MAXF && req_bps === {N{1'b1}}) saw_full = 1;
`ifdef BRAM_ARB_STATS_EN
            for (int i = 0; i < N; i++) check("stat_grants", stat_grants[i], grants[i]);
            check("stat_orphans", stat_orphans, orphans);
`endif
            if (mem_resp_valid) begin
                if (outq.size() == 0) orphans++;
                else if (!rbp[outq[0]]) void'(outq.pop_front());
            end
            if (load) begin
                outq.push_back(g);
                em_req = rq[g];
                em_v   = 1;
                last_g = g;
                grants[g]++;
                acc[g] = 1'b1;
            end else if (em_v && !mbp) begin
                em_v = 0;
            end
        end
        if (rst_now) begin
            outq.delete();
            em_v    = 0;
            em_req  = '0;
            last_g  = N - 1;
            orphans = 0;
            grants  = '{default: 0};
        end
        if (mem_resp_valid && mem_resp_bp === 1'b0) void'(ramq.pop_front());
        cyc++;
    endtask

    // Run n cycles; requesters in want raise a new request with pct% chance
    // when idle, and hold it until accepted.
    task automatic run(input int n, input logic [N-1:0] want, input int pct);
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < N; i++) begin
                if (want[i] && !rv[i] && $urandom_range(99) < pct) begin
                    rv[i] = 1'b1;
                    rq[i] = rand_req();
                end
            end
            step();
            for (int i = 0; i < N; i++) if (acc[i]) rv[i] = 1'b0;
        end
    endtask

    task automatic drain();
        rbp = '0;
        mbp = 1'b0;
        run(16, '0, 0);
    endtask

    task automatic issue_one(input int r, input logic [RW-1:0] req, input string tag);
        bit got;
        got   = 0;
        rq[r] = req;
        rv[r] = 1'b1;
        for (int c = 0; c < 8 && !got; c++) begin
            step();
            if (acc[r]) got = 1;
        end
        rv[r] = 1'b0;
        check(tag, got, 1'b1);
    endtask

    initial begin
        reset = 1'b1; req_valids = '0; reqs = '0; resp_bps = '0;
        mem_req_bp = 1'b0; mem_resp = '0; mem_resp_valid = 1'b0;
        rst_now = 1; rv = '0; rq = '0; rbp = '0; mbp = 0; lat = 0; cyc = 0;
        saw_full = 0; em_v = 0; em_req = '0; last_g = N - 1; orphans = 0;
        grants = '{default: 0};
        for (int i = 0; i < 256; i++) ram[i] = '0;
        for (int i = 0; i < N; i++) last_resp[i] = '0;

        // Reset, then one idle cycle checks the reset state
        run(2, '0, 0);
        rst_now = 0;
        run(1, '0, 0);

        // Single requester: write 0xA5 to address 5, read it back
        lat = 0;
        issue_one(2, {8'd5, 8'hA5, 1'b1}, "t1_write_accept");
        issue_one(2, {8'd5, 8'h00, 1'b0}, "t1_read_accept");
        run(4, '0, 0);
        check("t1_read_data", last_resp[2], 8'hA5);

        // All requesters continuously valid, zero-latency RAM
        run(12, 4'hF, 100);
        drain();

        // Latency 3: tag FIFO fills, next load waits for the first pop
        lat = 3;
        run(16, 4'hF, 100);
        drain();
        check("full_backpressure_seen", saw_full, 1'b1);

        // RAM port back-pressure held for 5 cycles
        lat = 1;
        run(2, 4'hF, 100);
        mbp = 1'b1;
        run(5, 4'hF, 100);
        mbp = 1'b0;
        run(4, 4'hF, 100);
        drain();

        // Response back-pressure for 2 cycles
        run(3, 4'hF, 100);
        rbp = 4'hF;
        run(2, '0, 0);
        rbp = '0;
        drain();

        // Reset with requests in flight; later responses are orphans
        lat = 3;
        run(2, 4'h1, 100);
        rst_now = 1;
        run(1, '0, 0);
        rst_now = 0;
        rv = '0;
        run(8, '0, 0);
        drain();

        // Randomised traffic across several RAM latencies
        for (int l = 0; l < 4; l++) begin
            lat = l;
            for (int c = 0; c < 200; c++) begin
                mbp     = ($urandom_range(3) == 0);
                rbp     = N'($urandom) & N'($urandom);
                rst_now = ($urandom_range(299) == 0);
                run(1, 4'hF, 60);
            end
            rst_now = 0;
            drain();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
